// File: rtl/low_mem_if.sv
// Bus between the cache controller (master) and the block memory model (slave).
interface low_mem_if #(
  parameter int BLOCK_SIZE = 8,
  parameter int LOW_SIZE   = 5
);
  localparam int BW = BLOCK_SIZE * 32;

  logic                Req_Low;
  logic                Wr_Low;
  logic [31:LOW_SIZE]  A_Low;
  logic [BW-1:0]       Din;
  logic [BW-1:0]       Dout;
  logic                Rdy_Low;
  logic                Busy;
  logic [31:0]         Rd_Cnt;
  logic [31:0]         Wr_Cnt;

  modport master (
    output Req_Low, Wr_Low, A_Low, Din,
    input  Dout, Rdy_Low, Busy, Rd_Cnt, Wr_Cnt
  );

  modport slave (
    input  Req_Low, Wr_Low, A_Low, Din,
    output Dout, Rdy_Low, Busy, Rd_Cnt, Wr_Cnt
  );
endinterface

// File: rtl/low_mem_model.sv
// Block-granular backing memory with a fixed request-to-completion latency.
// One transaction at a time: accept in IDLE, wait in BUSY, pulse Rdy_Low in RESP.
module low_mem_model #(
  parameter int BLOCK_SIZE = 8,
  parameter int LOW_SIZE   = 2 + $clog2(BLOCK_SIZE),
  parameter int MEM_AW     = 10,
  parameter int LATENCY    = 4
) (
  input logic      clk,
  input logic      rst_n,
  low_mem_if.slave bus
);
  localparam int BW = BLOCK_SIZE * 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nxt;
  logic [7:0]          lat_cnt, lat_cnt_nxt;
  logic                wr_q;
  logic [MEM_AW-1:0]   idx_q;
  logic [BW-1:0]       din_q;
  logic [BW-1:0]       mem [2**MEM_AW];

  logic [MEM_AW-1:0]   in_idx;
  logic [MEM_AW-1:0]   rd_idx;
  logic                accept;
  logic                rd_fill;
  logic                mem_we;
  logic                unused_addr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Upper address bits alias; they take no part in indexing.
  assign unused_addr = ^bus.A_Low;
  assign in_idx      = bus.A_Low[LOW_SIZE+MEM_AW-1:LOW_SIZE];
  assign accept      = (state == IDLE) && bus.Req_Low;
  // With LATENCY=1 the fetch goes straight from IDLE to RESP, so the live
  // inputs must steer the read; otherwise the latched transaction does.
  assign rd_idx      = (state == IDLE) ? in_idx : idx_q;
  assign rd_fill     = (state_nxt == RESP) && (state != RESP) &&
                       !((state == IDLE) ? bus.Wr_Low : wr_q);
  assign mem_we      = (state == RESP) && wr_q && rst_n;

  // Next-state and latency countdown.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      IDLE: begin
        if (bus.Req_Low) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt   = BUSY;
            lat_cnt_nxt = 8'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (lat_cnt == 8'd0) state_nxt = RESP;
        else                 lat_cnt_nxt = lat_cnt - 8'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= 8'd0;
      bus.Rdy_Low <= 1'b0;
      bus.Busy    <= 1'b0;
      bus.Rd_Cnt  <= 32'd0;
      bus.Wr_Cnt  <= 32'd0;
      bus.Dout    <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      bus.Rdy_Low <= (state_nxt == RESP);
      bus.Busy    <= (state_nxt != IDLE);
      if (rd_fill) bus.Dout <= mem[rd_idx];
      if (state == RESP) begin
        if (wr_q) bus.Wr_Cnt <= sat_inc(bus.Wr_Cnt);
        else      bus.Rd_Cnt <= sat_inc(bus.Rd_Cnt);
      end
    end
  end

  // Request latch and storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q  <= bus.Wr_Low;
      idx_q <= in_idx;
      din_q <= bus.Din;
    end
    if (mem_we) mem[idx_q] <= din_q;
  end
endmodule

// File: tb/tb_low_mem_model.sv
// Scoreboard bench for low_mem_model: stimulus pushes expected completions,
// a monitor pops them on every Rdy_Low pulse.
module tb_low_mem_model;
  localparam int BS = 8;
  localparam int LS = 5;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  low_mem_if #(.BLOCK_SIZE(BS), .LOW_SIZE(LS)) bus ();
  low_mem_if #(.BLOCK_SIZE(BS), .LOW_SIZE(LS)) bus1 ();

  low_mem_model #(.BLOCK_SIZE(BS), .LOW_SIZE(LS), .MEM_AW(AW), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  low_mem_model #(.BLOCK_SIZE(BS), .LOW_SIZE(LS), .MEM_AW(AW), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_wr;
    logic [255:0] dout;
    int           cyc;
    logic [31:0]  rd;
    logic [31:0]  wr;
  } exp_t;
  exp_t sbq[$];

  logic [31:0]  rd_m = 32'd0;
  logic [31:0]  wr_m = 32'd0;
  logic [255:0] last_dout = '0;

  localparam logic [255:0] D1 = {8{32'hDEADBEEF}};
  localparam logic [255:0] D2 = {8{32'h0BADF00D}};
  localparam logic [255:0] D3 = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
  localparam logic [255:0] D4 = {8{32'hCAFE1234}};
  localparam logic [255:0] DP = {8{32'h55AA55AA}};
  localparam logic [255:0] DQ = {8{32'hA5A5A5A5}};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Monitor: every Rdy_Low pulse must match the oldest outstanding transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Rdy_Low === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: Rdy_Low high in cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sbq.pop_front();
          check("rdy_cycle", 256'(cyc), 256'(e.cyc));
          check(e.is_wr ? "dout_hold" : "dout_fetch", bus.Dout, e.dout);
          @(negedge clk);
          check("rd_cnt", 256'(bus.Rd_Cnt), 256'(e.rd));
          check("wr_cnt", 256'(bus.Wr_Cnt), 256'(e.wr));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.Busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: Busy=%b after %0d cycles", bus.Busy, n);
    end
  endtask

  // Drive a request in the current (IDLE) cycle and record its expected completion.
  task automatic issue(input bit wr, input logic [26:0] a, input logic [255:0] d,
                       input logic [255:0] exp_dout);
    exp_t e;
    bus.Req_Low = 1'b1;
    bus.Wr_Low  = wr;
    bus.A_Low   = a;
    bus.Din     = d;
    if (wr) wr_m = sat(wr_m);
    else begin
      rd_m      = sat(rd_m);
      last_dout = exp_dout;
    end
    e.is_wr = wr;
    e.dout  = last_dout;
    e.cyc   = cyc + 4;
    e.rd    = rd_m;
    e.wr    = wr_m;
    sbq.push_back(e);
  endtask

  task automatic txn(input bit wr, input logic [26:0] a, input logic [255:0] d,
                     input logic [255:0] exp_dout);
    wait_idle();
    issue(wr, a, d, exp_dout);
    @(negedge clk);
    bus.Req_Low = 1'b0;
    bus.Din     = ~d;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.Req_Low  = 1'b0;
    bus.Wr_Low   = 1'b0;
    bus.A_Low    = '0;
    bus.Din      = '0;
    bus1.Req_Low = 1'b0;
    bus1.Wr_Low  = 1'b0;
    bus1.A_Low   = '0;
    bus1.Din     = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 256'(bus.Busy), 256'(0));
    check("rst_rdy", 256'(bus.Rdy_Low), 256'(0));
    check("rst_rd_cnt", 256'(bus.Rd_Cnt), 256'(0));
    check("rst_wr_cnt", 256'(bus.Wr_Cnt), 256'(0));
    check("rst_dout", bus.Dout, '0);

    // First request in the first cycle out of reset: write then fetch.
    rst_n = 1'b1;
    issue(1'b1, 27'h000123, D1, '0);
    @(negedge clk);
    bus.Req_Low = 1'b0;
    bus.Din     = '0;
    wait_idle();
    txn(1'b0, 27'h000123, '0, D1);

    // Aliasing modulo the depth.
    txn(1'b1, 27'h000405, D2, '0);
    txn(1'b0, 27'h000005, '0, D2);
    txn(1'b0, 27'h000123, '0, D1);

    // Back-to-back with inputs changing while busy.
    wait_idle();
    issue(1'b1, 27'h00002A, D3, '0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_%0d", k), 256'(bus.Busy), 256'(k != 5));
      if (k == 1) begin
        bus.Wr_Low = 1'b0;
        bus.A_Low  = 27'h00003F;
        bus.Din    = ~D3;
      end
      if (k == 4) bus.A_Low = 27'h00002A;
      if (k == 5) issue(1'b0, 27'h00002A, ~D3, D3);
      if (k == 6) begin
        bus.Req_Low = 1'b0;
        bus.A_Low   = 27'h00003F;
        bus.Din     = '0;
      end
    end
    wait_idle();

    // Reset during BUSY aborts the write-back.
    txn(1'b1, 27'h000077, DP, '0);
    bus.Req_Low = 1'b1;
    bus.Wr_Low  = 1'b1;
    bus.A_Low   = 27'h000077;
    bus.Din     = DQ;
    @(negedge clk);
    bus.Req_Low = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    rd_m      = 32'd0;
    wr_m      = 32'd0;
    last_dout = '0;
    check("abort_busy", 256'(bus.Busy), 256'(0));
    check("abort_rdy", 256'(bus.Rdy_Low), 256'(0));
    check("abort_wr_cnt", 256'(bus.Wr_Cnt), 256'(0));
    check("abort_dout", bus.Dout, '0);
    repeat (6) @(negedge clk);
    check("abort_wr_cnt_late", 256'(bus.Wr_Cnt), 256'(0));
    txn(1'b0, 27'h000077, '0, DP);

    // Fetch counter saturation.
    wait_idle();
    force bus.Rd_Cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release bus.Rd_Cnt;
    @(negedge clk);
    rd_m = 32'hFFFF_FFFE;
    check("rd_cnt_preset", 256'(bus.Rd_Cnt), 256'(32'hFFFF_FFFE));
    txn(1'b0, 27'h000123, '0, D1);
    txn(1'b0, 27'h000005, '0, D2);
    txn(1'b0, 27'h000123, '0, D1);

    // LATENCY=1 instance: held request, write then fetch.
    @(negedge clk);
    bus1.Req_Low = 1'b1;
    bus1.Wr_Low  = 1'b1;
    bus1.A_Low   = 27'h000009;
    bus1.Din     = D4;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("l1_rdy_%0d", k), 256'(bus1.Rdy_Low), 256'(k == 1 || k == 3));
      check($sformatf("l1_busy_%0d", k), 256'(bus1.Busy), 256'(k == 1 || k == 3));
      if (k == 1) begin
        bus1.Wr_Low = 1'b0;
        bus1.Din    = '0;
      end
      if (k == 2) check("l1_wr_cnt", 256'(bus1.Wr_Cnt), 256'(1));
      if (k == 3) begin
        check("l1_dout", bus1.Dout, D4);
        bus1.Req_Low = 1'b0;
      end
      if (k == 4) check("l1_rd_cnt", 256'(bus1.Rd_Cnt), 256'(1));
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 256'(sbq.size()), 256'(0));
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
